// File: rtl/usart_tx.sv
// usart_tx: 8N1 serial transmitter for the CPU USART link.
// Accepts a 32-bit word on a one-cycle `controle` strobe and sends
// NUM_BYTES of it, least significant byte first, back-to-back on Tx.
// Optional feature macro: USART_TX_PARITY_EN adds an even-parity bit
// after data bit 7, making each frame 11 bits instead of 10.
module usart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int NUM_BYTES    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        controle,
  input  logic [31:0] dado,
  output logic        Tx,
  output logic        ocupado,
  output logic        enviado
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]        BYTE_LAST = 2'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef USART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [1:0]          byte_q, byte_d;
  // The whole word shifts right once per data bit, so after eight shifts
  // the next byte is already sitting in the low bits for the next frame.
  logic [31:0]         shreg_q, shreg_d;
  logic                tx_q, tx_d;
  logic                ocupado_q, ocupado_d;
  logic                enviado_q, enviado_d;
  logic                bit_end;
`ifdef USART_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  assign bit_end = (baud_q == BAUD_LAST);

  // Next-state, counters and the registered line value for the next cycle.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    enviado_d = 1'b0;
`ifdef USART_TX_PARITY_EN
    par_d     = par_q;
`endif
    if (state_q != S_IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (controle) begin
          shreg_d = dado;
          byte_d  = 2'd0;
          bit_d   = 3'd0;
          baud_d  = '0;
          state_d = S_START;
          tx_d    = 1'b0;     // start bit goes out on the accepting edge
`ifdef USART_TX_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = {1'b0, shreg_q[31:1]};
`ifdef USART_TX_PARITY_EN
          par_d   = par_q ^ shreg_q[0];
`endif
          if (bit_q == 3'd7) begin
`ifdef USART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q ^ shreg_q[0];
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shreg_q[1];
          end
        end
      end
`ifdef USART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (byte_q == BYTE_LAST) begin
            state_d   = S_IDLE;
            enviado_d = 1'b1;
            tx_d      = 1'b1;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = S_START;
            tx_d    = 1'b0;
`ifdef USART_TX_PARITY_EN
            par_d   = 1'b0;
`endif
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    ocupado_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= 3'd0;
      byte_q    <= 2'd0;
      shreg_q   <= 32'd0;
      tx_q      <= 1'b1;
      ocupado_q <= 1'b0;
      enviado_q <= 1'b0;
`ifdef USART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      ocupado_q <= ocupado_d;
      enviado_q <= enviado_d;
`ifdef USART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign Tx      = tx_q;
  assign ocupado = ocupado_q;
  assign enviado = enviado_q;

endmodule

// File: tb/tb_usart_tx.sv
// tb_usart_tx: scoreboard bench for usart_tx with CLKS_PER_BIT=4.
// Two instances: one sending 1 byte per strobe, one sending 4.
// Expected per-cycle Tx values are queued when a strobe is driven and
// popped as each cycle's line value is sampled (#1 after the edge).
module tb_usart_tx;
  localparam int CPB = 4;
`ifdef USART_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif
  localparam int LEN1 = F * CPB;
  localparam int LEN4 = 4 * LEN1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        c1 = 1'b0, c4 = 1'b0;
  logic [31:0] d1 = '0, d4 = '0;
  logic        tx1, tx4, oc1, oc4, en1, en4;

  int   errors = 0;
  int   checks = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  usart_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(1)) dut1 (
    .clk(clk), .rst(rst), .controle(c1), .dado(d1),
    .Tx(tx1), .ocupado(oc1), .enviado(en1));

  usart_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(4)) dut4 (
    .clk(clk), .rst(rst), .controle(c4), .dado(d4),
    .Tx(tx4), .ocupado(oc4), .enviado(en4));

  // Reference framing: start 0, 8 data bits LSB first, [even parity], stop 1.
  task automatic push_frame(input logic [7:0] b);
    for (int c = 0; c < CPB; c++) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < CPB; c++) exp_q.push_back(b[i]);
`ifdef USART_TX_PARITY_EN
    for (int c = 0; c < CPB; c++) exp_q.push_back(^b);
`endif
    for (int c = 0; c < CPB; c++) exp_q.push_back(1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tx1, oc1, en1, tx4, oc4, en4} !== 6'b100100) begin
      errors++;
      $display("FAIL reset_hold: Tx/ocupado/enviado dut1=%b%b%b dut4=%b%b%b expected 100 100",
               tx1, oc1, en1, tx4, oc4, en4);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({tx1, oc1, en1, tx4, oc4, en4} !== 6'b100100) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: dut1=%b%b%b dut4=%b%b%b expected 100 100",
                 i, tx1, oc1, en1, tx4, oc4, en4);
      end
    end
  endtask

  task automatic test_single_byte(input logic [31:0] w);
    logic e;
    exp_q.delete();
    push_frame(w[7:0]);
    @(negedge clk);
    c1 = 1'b1; d1 = w;
    @(posedge clk); #1;
    c1 = 1'b0; d1 = ~w;
    for (int i = 0; i < LEN1; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      e = exp_q.pop_front();
      checks++;
      if (tx1 !== e || oc1 !== 1'b1 || en1 !== 1'b0) begin
        errors++;
        $display("FAIL single_byte w=%h cycle %0d: Tx/ocupado/enviado=%b%b%b expected %b10",
                 w, i, tx1, oc1, en1, e);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({tx1, oc1, en1} !== 3'b101) begin
      errors++;
      $display("FAIL single_byte_done w=%h: Tx/ocupado/enviado=%b%b%b expected 101",
               w, tx1, oc1, en1);
    end
    @(posedge clk); #1;
    checks++;
    if ({tx1, oc1, en1} !== 3'b100) begin
      errors++;
      $display("FAIL single_byte_after w=%h: Tx/ocupado/enviado=%b%b%b expected 100",
               w, tx1, oc1, en1);
    end
  endtask

  // With `ignore` set, a second strobe carrying all-ones lands 10 edges
  // into the transfer; the line must still carry the original word.
  task automatic test_four_bytes(input logic [31:0] w, input bit ignore);
    logic e;
    int   pulses;
    exp_q.delete();
    for (int b = 0; b < 4; b++) push_frame(w[8*b +: 8]);
    @(negedge clk);
    c4 = 1'b1; d4 = w;
    @(posedge clk); #1;
    c4 = 1'b0;
    for (int i = 0; i < LEN4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      e = exp_q.pop_front();
      checks++;
      if (tx4 !== e || oc4 !== 1'b1 || en4 !== 1'b0) begin
        errors++;
        $display("FAIL four_bytes w=%h ign=%0d cycle %0d: Tx/ocupado/enviado=%b%b%b expected %b10",
                 w, ignore, i, tx4, oc4, en4, e);
      end
      if (ignore && i == 9)  begin c4 = 1'b1; d4 = 32'hFFFF_FFFF; end
      if (ignore && i == 10) c4 = 1'b0;
    end
    @(posedge clk); #1;
    checks++;
    if ({tx4, oc4, en4} !== 3'b101) begin
      errors++;
      $display("FAIL four_bytes_done w=%h: Tx/ocupado/enviado=%b%b%b expected 101",
               w, tx4, oc4, en4);
    end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (en4 === 1'b1) pulses++;
      checks++;
      if (tx4 !== 1'b1 || oc4 !== 1'b0) begin
        errors++;
        $display("FAIL four_bytes_idle w=%h cycle %0d: Tx/ocupado=%b%b expected 10",
                 w, i, tx4, oc4);
      end
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL four_bytes_extra_enviado w=%h: %0d extra pulses, expected 0", w, pulses);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic e;
    exp_q.delete();
    push_frame(8'h5A);
    @(negedge clk);
    c1 = 1'b1; d1 = 32'h0000_005A;
    @(posedge clk); #1;
    c1 = 1'b0;
    for (int i = 0; i < 22; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      e = exp_q.pop_front();
      checks++;
      if (tx1 !== e || oc1 !== 1'b1) begin
        errors++;
        $display("FAIL midreset_pre cycle %0d: Tx/ocupado=%b%b expected %b1", i, tx1, oc1, e);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({tx1, oc1, en1} !== 3'b100) begin
        errors++;
        $display("FAIL midreset_hold cycle %0d: Tx/ocupado/enviado=%b%b%b expected 100",
                 i, tx1, oc1, en1);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    test_single_byte(32'h0000_00C3);
  endtask

  // A strobe held across the completion edge is refused, then taken on
  // the following edge after exactly one idle cycle.
  task automatic test_back_to_back();
    logic e;
    exp_q.delete();
    push_frame(8'h3C);
    @(negedge clk);
    c1 = 1'b1; d1 = 32'h0000_003C;
    @(posedge clk); #1;
    c1 = 1'b0;
    for (int i = 0; i < LEN1; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      e = exp_q.pop_front();
      checks++;
      if (tx1 !== e || oc1 !== 1'b1) begin
        errors++;
        $display("FAIL b2b_first cycle %0d: Tx/ocupado=%b%b expected %b1", i, tx1, oc1, e);
      end
    end
    c1 = 1'b1; d1 = 32'h0000_0081;
    @(posedge clk); #1;
    checks++;
    if ({tx1, oc1, en1} !== 3'b101) begin
      errors++;
      $display("FAIL b2b_refused: Tx/ocupado/enviado=%b%b%b expected 101", tx1, oc1, en1);
    end
    exp_q.delete();
    push_frame(8'h81);
    @(posedge clk); #1;
    c1 = 1'b0;
    for (int i = 0; i < LEN1; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      e = exp_q.pop_front();
      checks++;
      if (tx1 !== e || oc1 !== 1'b1 || en1 !== 1'b0) begin
        errors++;
        $display("FAIL b2b_second cycle %0d: Tx/ocupado/enviado=%b%b%b expected %b10",
                 i, tx1, oc1, en1, e);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({tx1, oc1, en1} !== 3'b101) begin
      errors++;
      $display("FAIL b2b_second_done: Tx/ocupado/enviado=%b%b%b expected 101", tx1, oc1, en1);
    end
  endtask

  // Fixed literal check of the A5 line pattern, independent of the model.
  task automatic test_literal_a5();
    logic [9:0] seq;
    logic [9:0] got;
    seq = 10'b1101001010;  // bit0 first: 0,1,0,1,0,0,1,0,1,1
    @(negedge clk);
    c1 = 1'b1; d1 = 32'h0000_00A5;
    @(posedge clk); #1;
    c1 = 1'b0;
    got = '0;
    for (int b = 0; b < 9; b++) begin
      @(posedge clk); #1;            // sample mid-bit
      got[b] = tx1;
      repeat (CPB - 1) @(posedge clk);
      #1;
    end
`ifdef USART_TX_PARITY_EN
    checks++;
    if (tx1 !== 1'b0) begin
      errors++;
      $display("FAIL a5_parity: got %b expected 0", tx1);
    end
    repeat (CPB) @(posedge clk);
    #1;
`endif
    got[9] = tx1;
    checks++;
    if (got !== seq) begin
      errors++;
      $display("FAIL a5_literal: line bits %b expected %b", got, seq);
    end
    repeat (CPB + 2) @(posedge clk);
    #1;
    checks++;
    if ({tx1, oc1} !== 2'b10) begin
      errors++;
      $display("FAIL a5_literal_idle: Tx/ocupado=%b%b expected 10", tx1, oc1);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte(32'h0000_00A5);
    test_single_byte(32'h0000_0007);
    test_single_byte(32'hDEAD_BE5A);
    test_literal_a5();
    test_four_bytes(32'h1234_5678, 1'b0);
    test_four_bytes(32'h1234_5678, 1'b1);
    test_reset_mid_frame();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/usart_tx.md
# usart_tx

Serial transmitter for the processor's USART link, the send-side counterpart of the existing receiver. It accepts a 32-bit word from the CPU output bus on a one-cycle `controle` strobe and shifts 1–4 of its bytes out on `Tx` as 8N1 frames, least significant byte first. It raises `ocupado` while sending and pulses `enviado` when the last stop bit completes. It sits beside the receiver in the system top and runs on the same divided `clk`.

## Interface
- `CLKS_PER_BIT`, default 4: `clk` cycles per serial bit. Valid range is 2 or more.
- `NUM_BYTES`, default 4: bytes sent per strobe, 1–4, starting with `dado[7:0]`.
- `clk` input, 1 bit: the single clock. All logic updates on its rising edge.
- `rst` input, 1 bit: synchronous, active-low reset.
- `controle` input, 1 bit: start strobe. Acted on only while idle.
- `dado` input, 32 bits: word to send. Sampled only on the accepting edge.
- `Tx` output, 1 bit: serial line, registered. Idles high.
- `ocupado` output, 1 bit: high from acceptance until the transfer completes.
- `enviado` output, 1 bit: one-cycle completion pulse.

## Operation
- **States:** IDLE, START, DATA, PARITY (present only with the macro), STOP.
- **IDLE:** `Tx`=1, `ocupado`=0.
  - `controle`=1 at an edge → latch `dado` into a shift register, clear the byte counter, go to START.
- **START:** `Tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
- **DATA:** 8 bits, LSB first, each held `CLKS_PER_BIT` cycles. Shift right once per bit.
  - After bit 7 → PARITY if the macro is defined, else STOP.
- **STOP:** `Tx`=1 for `CLKS_PER_BIT` cycles. At the end of the stop bit:
  - If bytes remaining: increment the byte counter, load the next byte (`dado` bits [15:8], then [23:16], then [31:24] of the latched word), go directly to START. No idle gap between bytes.
  - If last byte: go to IDLE and pulse `enviado`.
- **Counters:**
  - Baud counter: `$clog2(CLKS_PER_BIT)` bits, counts 0 .. `CLKS_PER_BIT`-1, then wraps and advances the bit.
  - Bit counter: 3 bits.
  - Byte counter: 2 bits.
- **Ignored inputs:**
  - `controle` while `ocupado`=1 is dropped: no queueing, no restart.
  - Changes on `dado` after acceptance have no effect.
- **Reset (`rst`=0 at an edge, any state, including mid-frame):**
  - Next state is IDLE.
  - `Tx`=1, `ocupado`=0, `enviado`=0.
  - All counters cleared; the partial frame is abandoned.
- **Reset priority:** reset overrides a simultaneous `controle`.

## Timing
- **Acceptance:** `controle`=1 with `ocupado`=0 at edge k.
  - From edge k: `ocupado`=1 and `Tx`=0, the start bit.
  - Zero-cycle latency to the line.
- **Frame length:** F = 10 bits, or 11 with parity.
- **Completion:** at edge k + `NUM_BYTES`·F·`CLKS_PER_BIT`:
  - `Tx`=1, `ocupado`=0, `enviado`=1 for exactly one cycle.
- **Back-to-back transfers:** a `controle` present at the completion edge is not accepted, because `ocupado` was still 1. A strobe at the next edge is accepted. The minimum spacing is therefore one idle cycle with `Tx`=1.
- **Output timing:** all outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `USART_TX_PARITY_EN`
  - **Defined:** after data bit 7, insert an even-parity bit for `CLKS_PER_BIT` cycles. The bit is the XOR of the 8 data bits. F=11.
  - **Undefined:** no PARITY state, F=10, pure 8N1.
- The macro must match the receiver's framing setting.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- **Reset:** hold `rst`=0 for 3 cycles, release → `Tx`=1, `ocupado`=0, `enviado`=0. Hold 20 idle cycles → outputs unchanged.
- **Single byte** (`NUM_BYTES`=1, no parity): `dado`=0x000000A5, strobe at edge k →
  - `Tx` bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - `enviado`=1 only at k+40; `ocupado` high for k..k+39.
- **Four bytes** (`NUM_BYTES`=4): `dado`=0x12345678 →
  - Bytes 0x78, 0x56, 0x34, 0x12 framed back-to-back with no gaps.
  - `enviado` at k+160.
- **Ignored inputs:**
  - Strobe `controle` again at k+10 with `dado`=0xFFFFFFFF → serial stream identical to the 0x12345678 case.
  - No second transfer starts.
  - `enviado` pulses exactly once.
- **Reset mid-frame:** `rst`=0 at k+22 →
  - Next edge: `Tx`=1, `ocupado`=0, no `enviado`.
  - A new strobe after release sends a complete, correct frame.
- **Parity** (`USART_TX_PARITY_EN`, `NUM_BYTES`=1):
  - 0xA5 → parity bit 0, `enviado` at k+44.
  - 0x07 → parity bit 1.
